and_operand_loader: RTL and testbench
=====================================

Name: and_operand_loader

Overview:
- Serial-to-parallel operand loader that sits directly upstream of the 8-input bitwise AND reducer.
- Accepts WIDTH-bit operands one per beat over a valid/ready stream and packs them into slots a..h.
- Once all eight slots are filled, it presents them together and holds them stable until the reducer side accepts.
- Also produces a registered AND of the packed set, used as a cross-check against the reducer output.

Parameters:
WIDTH, 16, operand and result width in bits.

Ports:
clk  input  1  single system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_data  input  WIDTH  operand beat.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  loader can accept a beat this cycle.
a, b, c, d, e, f, g, h  output  WIDTH each  packed operand slots 0..7 in arrival order (a first), to the reducer.
q_chk  output  WIDTH  registered a&b&c&d&e&f&g&h of the current packed set.
out_valid  output  1  slots a..h and q_chk are complete and stable.
out_ready  input  1  downstream has consumed the packed set.
fill_count  output  4  number of slots filled in the current set, 0..8.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low, and applied immediately on assertion. Release is synchronous to clk.
- Reset values:
  - a..h = 0, q_chk = 0.
  - out_valid = 0, fill_count = 0.
  - State FILL, so in_ready = 1 on the first cycle after release.
- States:
  - FILL: collecting; in_ready = 1 (combinational from state only, never from in_valid).
  - FULL: presenting; in_ready = 0, out_valid = 1.
- Accept rule: a beat is accepted on a rising edge with in_valid & in_ready.
  - The beat is written to slot[fill_count]; fill_count increments.
  - Slots not yet written in the current set hold their previous values.
- Transition FILL -> FULL: on the accepting edge of the 8th beat.
  - fill_count = 8, out_valid = 1, q_chk = AND of all eight slots including the new beat.
  - Latency: out_valid rises 1 cycle after the 8th accepted edge.
- FULL hold: a..h, q_chk and fill_count are frozen while out_valid & !out_ready. in_valid is ignored.
- Transition FULL -> FILL: on an edge with out_ready = 1.
  - out_valid = 0, fill_count = 0, in_ready = 1 the following cycle.
  - a..h and q_chk keep their values until overwritten.
  - No same-cycle bypass: a beat offered in the release cycle is not accepted and must be re-presented.
- Minimum throughput: one packed set per 9 cycles with out_ready held high.
- out_ready in FILL is ignored.
- Arithmetic: q_chk is a pure bitwise AND; no carries, no width growth.
- Reset mid-operation: a partial set is discarded. A pending FULL set is dropped and out_valid falls asynchronously.

Optional Feature:
- Macro: LOADER_FLUSH_EN.
- Defined: adds input port flush (1 bit).
  - If flush = 1 on an edge in FILL with fill_count >= 1, all unwritten slots are loaded with all-ones (the AND identity). fill_count becomes 8 and the state goes to FULL.
  - q_chk then equals the AND of the received beats only.
  - If in_valid is also high on that edge, the beat is accepted into slot[fill_count] first, then padding applies.
  - flush with fill_count = 0, or in FULL, is ignored.
- Not defined: no flush port; a set completes only after 8 accepted beats.

Test Plan:
- Reset release, in_valid = 1 with beats 0xFFFF, 0xFFFE, 0xFFFD, 0xFFFB, 0xFFF7, 0xFFEF, 0xFFDF, 0xFFBF on consecutive cycles -> out_valid = 1 one cycle after the 8th edge; a = 0xFFFF, h = 0xFFBF, q_chk = 0xFF80, fill_count = 8.
- Same set with out_ready = 0 for 5 cycles, and in_valid = 1 with in_data = 0x1234 throughout -> in_ready = 0, all outputs unchanged for 5 cycles. Raise out_ready -> out_valid = 0 and fill_count = 0 next cycle.
- Gapped input: 8 beats of 0x0F0F with in_valid toggling 1/0 -> set completes after 15 cycles; q_chk = 0x0F0F.
- Assert rst_n = 0 after 5 beats, release, then send 8 beats of 0xAAAA -> q_chk = 0xAAAA, fill_count sequence restarts at 0.
- Back-to-back: two sets with out_ready tied to 1 -> second set's beat 1 is accepted exactly 2 cycles after out_valid rose for the first set; q_chk correct for both.
- With LOADER_FLUSH_EN: beats 0x00FF, 0x0F0F, 0x3333, then flush = 1 with in_valid = 0 -> d..h = 0xFFFF, q_chk = 0x0003, out_valid next cycle. Flush with fill_count = 0 -> no change.

Source files
------------

// File: rtl/and_operand_loader_if.sv
// Stream and packed-set bundle between the operand loader and its neighbours.
// The flush signal is present only when LOADER_FLUSH_EN is defined.
interface and_operand_loader_if #(
  parameter int WIDTH = 16
) ();
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
  logic [WIDTH-1:0] q_chk;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       fill_count;
`ifdef LOADER_FLUSH_EN
  logic             flush;
`endif

  // Master drives beats and consumes packed sets; the loader is the slave.
  modport master (
`ifdef LOADER_FLUSH_EN
    output flush,
`endif
    output in_data, in_valid, out_ready,
    input  in_ready, a, b, c, d, e, f, g, h, q_chk, out_valid, fill_count
  );

  modport slave (
`ifdef LOADER_FLUSH_EN
    input  flush,
`endif
    input  in_data, in_valid, out_ready,
    output in_ready, a, b, c, d, e, f, g, h, q_chk, out_valid, fill_count
  );
endinterface

// File: rtl/and_operand_loader.sv
// Serial-to-parallel loader: packs eight WIDTH-bit beats into slots a..h and
// presents them with a registered AND cross-check. Define LOADER_FLUSH_EN for early flush.
module and_operand_loader #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  and_operand_loader_if.slave   bus
);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] slot_q [8];
  logic [WIDTH-1:0] slot_d [8];
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] q_chk_q, q_chk_d;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    slot_d    = slot_q;
    cnt_d     = cnt_q;
    q_chk_d   = q_chk_q;
    case (state)
      FILL: begin
        if (bus.in_valid) begin
          slot_d[cnt_q[2:0]] = bus.in_data;
          cnt_d              = cnt_q + 4'd1;
        end
`ifdef LOADER_FLUSH_EN
        // Pad unwritten slots with the AND identity so q_chk covers received beats only.
        if (bus.flush && (cnt_q != 4'd0)) begin
          for (int i = 0; i < 8; i++) begin
            if (4'(i) >= cnt_d) slot_d[i] = '1;
          end
          cnt_d = 4'd8;
        end
`endif
        if (cnt_d == 4'd8) begin
          state_nxt = FULL;
          q_chk_d   = '1;
          for (int i = 0; i < 8; i++) q_chk_d &= slot_d[i];
        end
      end
      FULL: begin
        // Release returns to FILL without taking a beat in the same cycle.
        if (bus.out_ready) begin
          state_nxt = FILL;
          cnt_d     = 4'd0;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FILL;
      cnt_q   <= 4'd0;
      q_chk_q <= '0;
      // NOTE: the slot array is reset because a..h are visible outputs that must read zero after reset.
      for (int i = 0; i < 8; i++) slot_q[i] <= '0;
    end else begin
      state   <= state_nxt;
      cnt_q   <= cnt_d;
      q_chk_q <= q_chk_d;
      slot_q  <= slot_d;
    end
  end

  assign bus.in_ready   = (state == FILL);
  assign bus.out_valid  = (state == FULL);
  assign bus.fill_count = cnt_q;
  assign bus.q_chk      = q_chk_q;
  assign bus.a          = slot_q[0];
  assign bus.b          = slot_q[1];
  assign bus.c          = slot_q[2];
  assign bus.d          = slot_q[3];
  assign bus.e          = slot_q[4];
  assign bus.f          = slot_q[5];
  assign bus.g          = slot_q[6];
  assign bus.h          = slot_q[7];

endmodule

// File: tb/tb_and_operand_loader.sv
// Scenario bench for and_operand_loader: a small model pushes expected sets into a
// scoreboard queue as beats are accepted; sets are popped when the DUT presents them.
module tb_and_operand_loader;
  localparam int WIDTH = 16;
  typedef logic [9*WIDTH-1:0] set_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  and_operand_loader_if #(.WIDTH(WIDTH)) ifc ();
  and_operand_loader #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  set_t             sb [$];
  logic [WIDTH-1:0] m_slot [8];
  int               m_cnt;
  bit               m_full;

  function automatic set_t dut_set();
    return {ifc.a, ifc.b, ifc.c, ifc.d, ifc.e, ifc.f, ifc.g, ifc.h, ifc.q_chk};
  endfunction

  function automatic set_t model_set();
    logic [WIDTH-1:0] acc;
    acc = '1;
    for (int i = 0; i < 8; i++) acc &= m_slot[i];
    return {m_slot[0], m_slot[1], m_slot[2], m_slot[3],
            m_slot[4], m_slot[5], m_slot[6], m_slot[7], acc};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_slot[i] = '0;
    m_cnt  = 0;
    m_full = 1'b0;
    sb.delete();
  endtask

  // One clock: capture what the DUT should see, advance the model, land #1 after the edge.
  task automatic step();
    bit               acc, rel, fl;
    logic [WIDTH-1:0] d;
    acc = (ifc.in_valid === 1'b1) && !m_full;
    rel = m_full && (ifc.out_ready === 1'b1);
    d   = ifc.in_data;
    fl  = 1'b0;
`ifdef LOADER_FLUSH_EN
    fl  = (ifc.flush === 1'b1) && !m_full && (m_cnt != 0);
`endif
    @(posedge clk);
    cyc++;
    if (rel) begin
      m_full = 1'b0;
      m_cnt  = 0;
    end else if (!m_full) begin
      if (acc) begin
        m_slot[m_cnt] = d;
        m_cnt++;
      end
      if (fl) begin
        for (int i = m_cnt; i < 8; i++) m_slot[i] = '1;
        m_cnt = 8;
      end
      if (m_cnt == 8) begin
        m_full = 1'b1;
        sb.push_back(model_set());
      end
    end
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", ifc.out_valid); end
    total++; if (ifc.fill_count !== 4'd0) begin bad++; $display("FAIL rst_fill_count got=%0d want=0", ifc.fill_count); end
    total++; if (dut_set() !== '0) begin bad++; $display("FAIL rst_slots got=%h want=0", dut_set()); end
    release_reset();
    total++; if (ifc.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", ifc.in_ready); end
  endtask

  task automatic test_fill();
    logic [WIDTH-1:0] beats [8];
    beats = '{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFB, 16'hFFF7, 16'hFFEF, 16'hFFDF, 16'hFFBF};
    for (int i = 0; i < 8; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_data  = beats[i];
      step();
      total++; if (ifc.fill_count !== 4'(i + 1)) begin bad++; $display("FAIL fill_count beat%0d got=%0d want=%0d", i, ifc.fill_count, i + 1); end
      total++; if (ifc.out_valid !== (i == 7)) begin bad++; $display("FAIL fill_out_valid beat%0d got=%b want=%b", i, ifc.out_valid, i == 7); end
    end
    total++; if (ifc.a !== 16'hFFFF) begin bad++; $display("FAIL fill_a got=%h want=ffff", ifc.a); end
    total++; if (ifc.h !== 16'hFFBF) begin bad++; $display("FAIL fill_h got=%h want=ffbf", ifc.h); end
    total++; if (ifc.q_chk !== 16'hFF80) begin bad++; $display("FAIL fill_q_chk got=%h want=ff80", ifc.q_chk); end
    total++; if (ifc.in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%b want=0", ifc.in_ready); end
  endtask

  task automatic test_hold();
    set_t held, exp;
    held = dut_set();
    ifc.in_valid  = 1'b1;
    ifc.in_data   = 16'h1234;
    ifc.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (ifc.in_ready !== 1'b0 || ifc.out_valid !== 1'b1) begin bad++; $display("FAIL hold_hs cyc%0d in_ready=%b out_valid=%b want 0/1", i, ifc.in_ready, ifc.out_valid); end
      total++; if (dut_set() !== held || ifc.fill_count !== 4'd8) begin bad++; $display("FAIL hold_stable cyc%0d got=%h cnt=%0d want=%h cnt=8", i, dut_set(), ifc.fill_count, held); end
    end
    ifc.out_ready = 1'b1;
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL hold_sb got=empty want=set"); end
    else begin exp = sb.pop_front(); if (dut_set() !== exp) begin bad++; $display("FAIL hold_set got=%h want=%h", dut_set(), exp); end end
    step();
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
    total++; if (ifc.out_valid !== 1'b0 || ifc.fill_count !== 4'd0) begin bad++; $display("FAIL release out_valid=%b cnt=%0d want 0/0", ifc.out_valid, ifc.fill_count); end
    total++; if (ifc.q_chk !== 16'hFF80) begin bad++; $display("FAIL release_keep q_chk got=%h want=ff80", ifc.q_chk); end
    step();
    total++; if (ifc.fill_count !== 4'd0) begin bad++; $display("FAIL no_bypass cnt got=%0d want=0", ifc.fill_count); end
  endtask

  task automatic test_gapped();
    int   risen;
    set_t exp;
    risen = -1;
    ifc.in_data = 16'h0F0F;
    for (int i = 0; i < 15; i++) begin
      ifc.in_valid = (i % 2 == 0);
      step();
      if (ifc.out_valid === 1'b1 && risen < 0) risen = i + 1;
    end
    ifc.in_valid = 1'b0;
    total++; if (risen !== 15) begin bad++; $display("FAIL gapped_latency got=%0d want=15", risen); end
    total++; if (ifc.q_chk !== 16'h0F0F) begin bad++; $display("FAIL gapped_q_chk got=%h want=0f0f", ifc.q_chk); end
    ifc.out_ready = 1'b1;
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL gapped_sb got=empty want=set"); end
    else begin exp = sb.pop_front(); if (dut_set() !== exp) begin bad++; $display("FAIL gapped_set got=%h want=%h", dut_set(), exp); end end
    step();
    ifc.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_t exp;
    for (int i = 0; i < 5; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_data  = 16'(16'h1111 * (i + 1));
      step();
    end
    ifc.in_valid = 1'b0;
    total++; if (ifc.fill_count !== 4'd5) begin bad++; $display("FAIL partial_cnt got=%0d want=5", ifc.fill_count); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (ifc.fill_count !== 4'd0) begin bad++; $display("FAIL async_partial cnt got=%0d want=0", ifc.fill_count); end
    model_reset();
    release_reset();
    for (int i = 0; i < 8; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_data  = 16'hC3C3;
      step();
    end
    ifc.in_valid = 1'b0;
    total++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL pend_full got=%b want=1", ifc.out_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (ifc.out_valid !== 1'b0 || ifc.a !== '0) begin bad++; $display("FAIL async_drop out_valid=%b a=%h want 0/0", ifc.out_valid, ifc.a); end
    model_reset();
    release_reset();
    total++; if (ifc.fill_count !== 4'd0) begin bad++; $display("FAIL restart_cnt got=%0d want=0", ifc.fill_count); end
    for (int i = 0; i < 8; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_data  = 16'hAAAA;
      step();
      total++; if (ifc.fill_count !== 4'(i + 1)) begin bad++; $display("FAIL restart_seq beat%0d got=%0d want=%0d", i, ifc.fill_count, i + 1); end
    end
    ifc.in_valid = 1'b0;
    total++; if (ifc.q_chk !== 16'hAAAA) begin bad++; $display("FAIL restart_q_chk got=%h want=aaaa", ifc.q_chk); end
    ifc.out_ready = 1'b1;
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL restart_sb got=empty want=set"); end
    else begin exp = sb.pop_front(); if (dut_set() !== exp) begin bad++; $display("FAIL restart_set got=%h want=%h", dut_set(), exp); end end
    step();
    ifc.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] data [16];
    int   idx, rose, acc1, seen;
    bit   will_acc;
    set_t exp;
    for (int i = 0; i < 16; i++) data[i] = 16'($urandom) | 16'hF00F;
    idx = 0; rose = -1; acc1 = -1; seen = 0;
    ifc.out_ready = 1'b1;
    for (int n = 0; n < 40 && (idx < 16 || m_full); n++) begin
      ifc.in_valid = (idx < 16);
      ifc.in_data  = (idx < 16) ? data[idx] : '0;
      will_acc = (idx < 16) && !m_full;
      step();
      if (will_acc) idx++;
      if (rose >= 0 && acc1 < 0 && ifc.fill_count === 4'd1) acc1 = cyc;
      if (ifc.out_valid === 1'b1) begin
        if (rose < 0) rose = cyc;
        seen++;
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL b2b_sb got=empty want=set"); end
        else begin exp = sb.pop_front(); if (dut_set() !== exp) begin bad++; $display("FAIL b2b_set%0d got=%h want=%h", seen, dut_set(), exp); end end
      end
    end
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
    total++; if (seen !== 2) begin bad++; $display("FAIL b2b_sets got=%0d want=2", seen); end
    total++; if (acc1 - rose !== 2) begin bad++; $display("FAIL b2b_gap got=%0d want=2", acc1 - rose); end
  endtask

`ifdef LOADER_FLUSH_EN
  task automatic test_flush();
    logic [WIDTH-1:0] beats [3];
    set_t exp;
    beats = '{16'h00FF, 16'h0F0F, 16'h3333};
    for (int i = 0; i < 3; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_data  = beats[i];
      step();
    end
    ifc.in_valid = 1'b0;
    ifc.flush    = 1'b1;
    step();
    ifc.flush    = 1'b0;
    total++; if (ifc.out_valid !== 1'b1 || ifc.fill_count !== 4'd8) begin bad++; $display("FAIL flush_full out_valid=%b cnt=%0d want 1/8", ifc.out_valid, ifc.fill_count); end
    total++; if ({ifc.d, ifc.e, ifc.f, ifc.g, ifc.h} !== {5{16'hFFFF}}) begin bad++; $display("FAIL flush_pad d=%h h=%h want=ffff", ifc.d, ifc.h); end
    total++; if (ifc.q_chk !== 16'h0003) begin bad++; $display("FAIL flush_q_chk got=%h want=0003", ifc.q_chk); end
    ifc.out_ready = 1'b1;
    total++;
    if (sb.size() == 0) begin bad++; $display("FAIL flush_sb got=empty want=set"); end
    else begin exp = sb.pop_front(); if (dut_set() !== exp) begin bad++; $display("FAIL flush_set got=%h want=%h", dut_set(), exp); end end
    step();
    ifc.out_ready = 1'b0;
    ifc.flush     = 1'b1;
    step();
    ifc.flush     = 1'b0;
    total++; if (ifc.out_valid !== 1'b0 || ifc.fill_count !== 4'd0) begin bad++; $display("FAIL flush_empty out_valid=%b cnt=%0d want 0/0", ifc.out_valid, ifc.fill_count); end
  endtask
`endif

  initial begin
    ifc.in_data   = '0;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b0;
`ifdef LOADER_FLUSH_EN
    ifc.flush     = 1'b0;
`endif
    model_reset();
    test_reset();
    test_fill();
    test_hold();
    test_gapped();
    test_reset_mid();
    test_back_to_back();
`ifdef LOADER_FLUSH_EN
    test_flush();
`endif
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d want=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
